// File: rtl/execute.sv
// Y86-64 execute stage: combinational ALU result and branch/move condition,
// backed by a ZF/SF/OF condition-code register that only OPq updates.
module execute (
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [63:0] valC,
  input  logic [63:0] valA,
  input  logic [63:0] valB,
  output logic [63:0] valE,
  output logic        Cnd,
  input  logic        clk,
  input  logic        reset
);

  logic r_zf, r_sf, r_of;
  logic w_op_ok;
  logic w_cc_load;
  logic w_new_of;
  logic w_lt;
  logic w_cond;

  assign w_op_ok   = (ifun[3:2] == 2'b00);
  assign w_cc_load = (icode == 4'h6) && w_op_ok;

  always_comb begin
    valE = 64'd0;
    case (icode)
      4'h2:        valE = valA;
      4'h3:        valE = valC;
      4'h4, 4'h5:  valE = valB + valC;
      4'h6: begin
        case (ifun)
          4'h0:    valE = valB + valA;
          4'h1:    valE = valB - valA;
          4'h2:    valE = valB & valA;
          4'h3:    valE = valB ^ valA;
          default: valE = 64'd0;
        endcase
      end
      4'h8, 4'hA:  valE = valB - 64'd8;
      4'h9, 4'hB:  valE = valB + 64'd8;
      default:     valE = 64'd0;
    endcase
  end

  // Signed overflow: operands agree in sign (add) or differ (sub, valB - valA)
  // and the result's sign departs from valB.
  always_comb begin
    w_new_of = 1'b0;
    case (ifun)
      4'h0:    w_new_of = (valA[63] == valB[63]) && (valE[63] != valB[63]);
      4'h1:    w_new_of = (valA[63] != valB[63]) && (valE[63] != valB[63]);
      default: w_new_of = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_zf <= 1'b1;
      r_sf <= 1'b0;
      r_of <= 1'b0;
    end else if (w_cc_load) begin
      r_zf <= (valE == 64'd0);
      r_sf <= valE[63];
      r_of <= w_new_of;
    end
  end

  assign w_lt = r_sf ^ r_of;

  always_comb begin
    w_cond = 1'b0;
    case (ifun)
      4'h0:    w_cond = 1'b1;
      4'h1:    w_cond = w_lt | r_zf;
      4'h2:    w_cond = w_lt;
      4'h3:    w_cond = r_zf;
      4'h4:    w_cond = ~r_zf;
      4'h5:    w_cond = ~w_lt;
      4'h6:    w_cond = ~w_lt & ~r_zf;
      default: w_cond = 1'b0;
    endcase
  end

  assign Cnd = ((icode == 4'h2) || (icode == 4'h7)) ? w_cond : 1'b0;

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for execute: directed scenarios plus randomized
// instructions checked against a flag-level reference model.
module tb_execute;

  logic [3:0]  icode, ifun;
  logic [63:0] valC, valA, valB;
  logic [63:0] valE;
  logic        Cnd;
  logic        clk, reset;

  int errors = 0;
  int checks = 0;

  logic m_zf, m_sf, m_of;

  execute dut (
    .icode(icode), .ifun(ifun), .valC(valC), .valA(valA), .valB(valB),
    .valE(valE), .Cnd(Cnd), .clk(clk), .reset(reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_vale(input logic [3:0] ic, input logic [3:0] fn,
                                           input logic [63:0] c, input logic [63:0] a,
                                           input logic [63:0] b);
    case (ic)
      4'h2: return a;
      4'h3: return c;
      4'h4, 4'h5: return b + c;
      4'h6: begin
        if (fn == 0) return b + a;
        if (fn == 1) return b - a;
        if (fn == 2) return b & a;
        if (fn == 3) return b ^ a;
        return 64'd0;
      end
      4'h8, 4'hA: return b - 64'd8;
      4'h9, 4'hB: return b + 64'd8;
      default: return 64'd0;
    endcase
  endfunction

  // Overflow judged by whether the exact 65-bit signed result fits in 64 bits.
  function automatic logic ref_of(input logic [3:0] fn, input logic [63:0] a,
                                  input logic [63:0] b);
    logic signed [64:0] sa, sb, r;
    sa = {a[63], a};
    sb = {b[63], b};
    if (fn == 0) r = sb + sa;
    else if (fn == 1) r = sb - sa;
    else return 1'b0;
    return r[64] != r[63];
  endfunction

  function automatic logic ref_cnd(input logic [3:0] ic, input logic [3:0] fn);
    logic less;
    if (ic != 4'h2 && ic != 4'h7) return 1'b0;
    less = m_sf ^ m_of;
    case (fn)
      4'h0: return 1'b1;
      4'h1: return less | m_zf;
      4'h2: return less;
      4'h3: return m_zf;
      4'h4: return !m_zf;
      4'h5: return !less;
      4'h6: return !less && !m_zf;
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_in(input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] c, input logic [63:0] a, input logic [63:0] b);
    icode = ic; ifun = fn; valC = c; valA = a; valB = b;
    #1;
  endtask

  task automatic clock_edge();
    logic upd;
    logic [63:0] e;
    logic o;
    upd = (icode == 4'h6) && (ifun <= 4'h3);
    e = ref_vale(icode, ifun, valC, valA, valB);
    o = ref_of(ifun, valA, valB);
    @(posedge clk);
    if (upd && !reset) begin
      m_zf = (e == 64'd0);
      m_sf = e[63];
      m_of = o;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [6:0] exp_j;
    exp_j = 7'b0101011;  // bit i = expected Cnd for jXX ifun i after reset
    reset = 1'b1;
    m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
    set_in(4'h6, 4'h1, 64'd0, 64'd9, 64'd1);
    clock_edge();
    for (int i = 0; i < 7; i++) begin
      set_in(4'h7, i[3:0], 64'd0, 64'd0, 64'd0);
      checks++;
      if (Cnd !== exp_j[i]) begin
        errors++;
        $display("FAIL reset_cnd ifun=%0d: got %b expected %b", i, Cnd, exp_j[i]);
      end
    end
    set_in(4'h3, 4'h0, 64'h1234_5678_9ABC_DEF0, 64'd0, 64'd0);
    checks++;
    if (valE !== 64'h1234_5678_9ABC_DEF0) begin
      errors++;
      $display("FAIL reset_vale: got %h expected %h", valE, 64'h1234_5678_9ABC_DEF0);
    end
    reset = 1'b0;
    clock_edge();
  endtask

  task automatic test_add_sequence();
    logic [63:0] exp_v [3];
    exp_v = '{64'd0, 64'd1, 64'd2};
    for (int i = 0; i < 3; i++) begin
      set_in(4'h6, 4'h0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'(i + 1));
      checks++;
      if (valE !== exp_v[i]) begin
        errors++;
        $display("FAIL add_seq_vale[%0d]: got %h expected %h", i, valE, exp_v[i]);
      end
      clock_edge();
      set_in(4'h7, 4'h3, 64'd0, 64'd0, 64'd0);
      checks++;
      if (Cnd !== (i == 0)) begin
        errors++;
        $display("FAIL add_seq_je[%0d]: got %b expected %b", i, Cnd, (i == 0));
      end
      if (i == 1) begin
        set_in(4'h7, 4'h1, 64'd0, 64'd0, 64'd0);
        checks++;
        if (Cnd !== 1'b0) begin
          errors++;
          $display("FAIL add_seq_jle: got %b expected 0", Cnd);
        end
      end
    end
  endtask

  task automatic test_overflow();
    set_in(4'h6, 4'h0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF);
    checks++;
    if (valE !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      errors++;
      $display("FAIL ovf_vale: got %h expected fffffffffffffffe", valE);
    end
    clock_edge();
    set_in(4'h7, 4'h2, 64'd0, 64'd0, 64'd0);
    checks++;
    if (Cnd !== 1'b0) begin errors++; $display("FAIL ovf_jl: got %b expected 0", Cnd); end
    set_in(4'h7, 4'h5, 64'd0, 64'd0, 64'd0);
    checks++;
    if (Cnd !== 1'b1) begin errors++; $display("FAIL ovf_jge: got %b expected 1", Cnd); end
  endtask

  task automatic test_sub();
    logic [3:0] fn [3];
    logic       ex [3];
    fn = '{4'h2, 4'h6, 4'h4};
    ex = '{1'b1, 1'b0, 1'b1};
    set_in(4'h6, 4'h1, 64'd0, 64'd7, 64'd5);
    checks++;
    if (valE !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      errors++;
      $display("FAIL sub_vale: got %h expected fffffffffffffffe", valE);
    end
    clock_edge();
    for (int i = 0; i < 3; i++) begin
      set_in(4'h7, fn[i], 64'd0, 64'd0, 64'd0);
      checks++;
      if (Cnd !== ex[i]) begin
        errors++;
        $display("FAIL sub_cnd ifun=%0d: got %b expected %b", fn[i], Cnd, ex[i]);
      end
    end
  endtask

  task automatic test_logic_addr();
    logic [3:0]  ic [5];
    logic [3:0]  fn [5];
    logic [63:0] c  [5];
    logic [63:0] b  [5];
    logic [63:0] ex [5];
    set_in(4'h6, 4'h2, 64'd0, 64'h0F, 64'hF0);
    checks++;
    if (valE !== 64'd0) begin errors++; $display("FAIL and_vale: got %h expected 0", valE); end
    clock_edge();
    set_in(4'h7, 4'h3, 64'd0, 64'd0, 64'd0);
    checks++;
    if (Cnd !== 1'b1) begin errors++; $display("FAIL and_je: got %b expected 1", Cnd); end
    ic = '{4'h6, 4'hA, 4'hB, 4'h5, 4'h3};
    fn = '{4'h3, 4'h0, 4'h0, 4'h0, 4'h0};
    c  = '{64'h0, 64'h0, 64'h0, 64'h20, 64'h55};
    b  = '{64'hFF, 64'h100, 64'h100, 64'h10, 64'h0};
    ex = '{64'hF0, 64'hF8, 64'h108, 64'h30, 64'h55};
    for (int i = 0; i < 5; i++) begin
      set_in(ic[i], fn[i], c[i], 64'h0F, b[i]);
      checks++;
      if (valE !== ex[i]) begin
        errors++;
        $display("FAIL logic_addr icode=%h: got %h expected %h", ic[i], valE, ex[i]);
      end
    end
    clock_edge();
  endtask

  task automatic test_reset_mid();
    set_in(4'h6, 4'h1, 64'd0, 64'd7, 64'd5);
    clock_edge();
    set_in(4'h7, 4'h2, 64'd0, 64'd0, 64'd0);
    checks++;
    if (Cnd !== 1'b1) begin errors++; $display("FAIL rstmid_jl_before: got %b expected 1", Cnd); end
    #1 reset = 1'b1;
    m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
    #1;
    checks++;
    if (Cnd !== 1'b0) begin errors++; $display("FAIL rstmid_jl_after: got %b expected 0", Cnd); end
    set_in(4'h7, 4'h3, 64'd0, 64'd0, 64'd0);
    checks++;
    if (Cnd !== 1'b1) begin errors++; $display("FAIL rstmid_je_after: got %b expected 1", Cnd); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_hold();
    set_in(4'h6, 4'h3, 64'd0, 64'h33, 64'h33);
    clock_edge();
    set_in(4'h1, 4'h0, 64'd0, 64'd1, 64'd2);
    clock_edge();
    set_in(4'h3, 4'h0, 64'h8000_0000_0000_0000, 64'd0, 64'd0);
    clock_edge();
    set_in(4'h6, 4'h7, 64'd0, 64'd3, 64'h8000_0000_0000_0000);
    checks++;
    if (valE !== 64'd0) begin errors++; $display("FAIL bad_opq_vale: got %h expected 0", valE); end
    clock_edge();
    set_in(4'h7, 4'h3, 64'd0, 64'd0, 64'd0);
    checks++;
    if (Cnd !== 1'b1) begin errors++; $display("FAIL hold_je: got %b expected 1", Cnd); end
    set_in(4'h2, 4'h1, 64'd0, 64'd0, 64'd0);
    checks++;
    if (Cnd !== 1'b1) begin errors++; $display("FAIL hold_cmovle: got %b expected 1", Cnd); end
  endtask

  task automatic test_random();
    logic [63:0] a, b, c, e;
    logic [3:0]  ic, fn;
    logic        cx;
    for (int n = 0; n < 300; n++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      c = {$urandom, $urandom};
      if (n % 4 == 1) a = {a[63], 63'd0} | 64'(a[3:0]);
      if (n % 5 == 2) b = a;
      ic = (n % 3 == 0) ? 4'h6 : 4'($urandom_range(0, 15));
      fn = (n % 7 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      set_in(ic, fn, c, a, b);
      e = ref_vale(ic, fn, c, a, b);
      cx = ref_cnd(ic, fn);
      checks++;
      if (valE !== e) begin
        errors++;
        $display("FAIL rand_vale n=%0d icode=%h ifun=%h: got %h expected %h", n, ic, fn, valE, e);
      end
      checks++;
      if (Cnd !== cx) begin
        errors++;
        $display("FAIL rand_cnd n=%0d icode=%h ifun=%h: got %b expected %b", n, ic, fn, Cnd, cx);
      end
      clock_edge();
      fn = 4'($urandom_range(0, 8));
      set_in(4'h7, fn, 64'd0, 64'd0, 64'd0);
      cx = ref_cnd(4'h7, fn);
      checks++;
      if (Cnd !== cx) begin
        errors++;
        $display("FAIL rand_jxx n=%0d ifun=%h: got %b expected %b", n, fn, Cnd, cx);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    icode = 4'h0; ifun = 4'h0; valC = 64'd0; valA = 64'd0; valB = 64'd0;
    m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
    @(negedge clk);
    test_reset();
    test_add_sequence();
    test_overflow();
    test_sub();
    test_logic_addr();
    test_reset_mid();
    test_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
